// File: rtl/trans_issue_arbiter.sv
// Round-robin issue arbiter: grants one producer at a time to the validator, injects the
// block-start flag on demand, drops issues that are never acknowledged and counts events.
module trans_issue_arbiter #(
    parameter int N_SRC       = 4,
    parameter int ACK_TIMEOUT = 4096,
    parameter int GW          = $clog2(N_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 block_start_i,
    input  logic [N_SRC*128-1:0] src_data_i,
    input  logic [N_SRC-1:0]     src_valid_i,
    output logic [N_SRC-1:0]     src_ready_o,
    output logic [127:0]         data_o,
    output logic                 valid_o,
    input  logic                 ack_i,
    input  logic                 accept_i,
    output logic [GW-1:0]        grant_o,
    output logic                 busy_o,
    output logic [31:0]          issued_cnt_o,
    output logic [31:0]          accepted_cnt_o,
    output logic [31:0]          dropped_cnt_o,
    output logic                 timeout_err_o
);

    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StIssue} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   win;
    logic            win_found;
    logic [GW:0]     rr_sum;
    logic [127:0]    win_data;
    logic [TW-1:0]   tcnt;
    logic            blk_pend;

    // Search starts one past the last grant; one subtraction suffices since the sum < 2*N_SRC.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        rr_sum    = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            rr_sum = {1'b0, last_grant} + (GW+1)'(i);
            if (rr_sum >= (GW+1)'(N_SRC)) begin
                rr_sum = rr_sum - (GW+1)'(N_SRC);
            end
            if (!win_found && src_valid_i[rr_sum[GW-1:0]]) begin
                win_found = 1'b1;
                win       = rr_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        win_data = src_data_i[0 +: 128];
        for (int k = 0; k < N_SRC; k++) begin
            if (win == GW'(k)) begin
                win_data = src_data_i[k*128 +: 128];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            last_grant     <= GW'(N_SRC - 1);
            grant_o        <= GW'(N_SRC - 1);
            data_o         <= '0;
            valid_o        <= 1'b0;
            src_ready_o    <= '0;
            busy_o         <= 1'b0;
            tcnt           <= '0;
            blk_pend       <= 1'b0;
            issued_cnt_o   <= '0;
            accepted_cnt_o <= '0;
            dropped_cnt_o  <= '0;
            timeout_err_o  <= 1'b0;
        end else begin
            src_ready_o <= '0;
            if (accept_i) begin
                accepted_cnt_o <= accepted_cnt_o + 32'd1;
            end
            if (block_start_i) begin
                blk_pend <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (en_i && win_found) begin
                        // A block-start pulse on the grant edge is consumed by this grant.
                        data_o      <= {win_data[127:10], win_data[9] | blk_pend | block_start_i,
                                        win_data[8:0]};
                        blk_pend    <= 1'b0;
                        src_ready_o <= {{(N_SRC-1){1'b0}}, 1'b1} << win;
                        valid_o     <= 1'b1;
                        grant_o     <= win;
                        tcnt        <= '0;
                        busy_o      <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    if (ack_i) begin
                        valid_o      <= 1'b0;
                        busy_o       <= 1'b0;
                        last_grant   <= grant_o;
                        issued_cnt_o <= issued_cnt_o + 32'd1;
                        state        <= StIdle;
                    end else if (tcnt == TMAX) begin
                        valid_o       <= 1'b0;
                        busy_o        <= 1'b0;
                        last_grant    <= grant_o;
                        dropped_cnt_o <= dropped_cnt_o + 32'd1;
                        timeout_err_o <= 1'b1;
                        state         <= StIdle;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_trans_issue_arbiter.sv
// Scoreboard bench for trans_issue_arbiter: directed producer/validator traffic, a monitor
// checks every grant (source, payload, ready pulse, valid width) against queued expectations.
module tb_trans_issue_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b1;
    logic           block_start = 1'b0;
    logic [N*128-1:0] src_data;
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_ready;
    logic [127:0]   data;
    logic           valid;
    logic           ack = 1'b0;
    logic           accept = 1'b0;
    logic [1:0]     grant;
    logic           busy;
    logic [31:0]    issued_cnt, accepted_cnt, dropped_cnt;
    logic           timeout_err;

    trans_issue_arbiter #(.N_SRC(N), .ACK_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .block_start_i  (block_start),
        .src_data_i     (src_data),
        .src_valid_i    (src_valid),
        .src_ready_o    (src_ready),
        .data_o         (data),
        .valid_o        (valid),
        .ack_i          (ack),
        .accept_i       (accept),
        .grant_o        (grant),
        .busy_o         (busy),
        .issued_cnt_o   (issued_cnt),
        .accepted_cnt_o (accepted_cnt),
        .dropped_cnt_o  (dropped_cnt),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   g;
        logic [127:0] d;
        int           len;   // expected valid_o width in cycles
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Producers: source k holds valid while loaded[k] > used[k].
    int   loaded[N] = '{default: 0};
    int   used[N]   = '{default: 0};
    logic auto_ack = 1'b1;
    logic acc_follow = 1'b0;

    always_comb begin
        for (int k = 0; k < N; k++) src_valid[k] = (loaded[k] > used[k]);
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) if (src_ready[k]) used[k] = used[k] + 1;
    end

    // Registered validator: ack one cycle after it sees valid_o.
    always @(posedge clk) begin
        if (rst) begin
            ack    <= 1'b0;
            accept <= 1'b0;
        end else begin
            ack    <= auto_ack && valid && !ack;
            accept <= acc_follow && auto_ack && valid && !ack;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pay(input int k);
        return {32'hA000_0000 + k, 32'hB000_1000 + k, 32'h1234_5678, 32'h0000_00F0 + k};
    endfunction

    task automatic push(input int g, input logic [127:0] d, input int len);
        exp_t e;
        e.g = 2'(g);
        e.d = d;
        e.len = len;
        sb.push_back(e);
    endtask

    // Monitor: pops an expectation on each rising valid_o and checks its width on the fall.
    logic prev_v = 1'b0;
    int   hi_len = 0;
    int   cur_len = 0;
    always @(negedge clk) begin
        if (valid && !prev_v) begin
            hi_len = 1;
            check("grant_expected", 128'(sb.size() > 0), 128'd1);
            if (sb.size() > 0) begin
                exp_t e;
                logic [3:0] oh;
                e = sb.pop_front();
                oh = 4'b0001 << e.g;
                check("grant_idx", 128'(grant), 128'(e.g));
                check("grant_data", data, e.d);
                check("grant_ready", 128'(src_ready), 128'(oh));
                cur_len = e.len;
            end else begin
                cur_len = 0;
            end
        end else if (valid) begin
            hi_len++;
        end else if (prev_v && cur_len != 0) begin
            check("valid_width", 128'(hi_len), 128'(cur_len));
        end
        prev_v = valid;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_valid", 128'(valid), 128'd0);
        check("rst_ready", 128'(src_ready), 128'd0);
        check("rst_data", data, 128'd0);
        check("rst_grant", 128'(grant), 128'd3);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_issued", 128'(issued_cnt), 128'd0);
        check("rst_accepted", 128'(accepted_cnt), 128'd0);
        check("rst_dropped", 128'(dropped_cnt), 128'd0);
        check("rst_terr", 128'(timeout_err), 128'd0);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !valid;
            for (int k = 0; k < N; k++) if (loaded[k] > used[k]) done = 1'b0;
        end
        check(name, 128'(done), 128'd1);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = valid;
        end
        check(name, 128'(seen), 128'd1);
    endtask

    initial begin
        for (int k = 0; k < N; k++) src_data[k*128 +: 128] = pay(k);
        src_data[0 +: 128] = {16{8'hA5}};

        // Reset state, then a single source-0 transaction.
        do_reset();
        check_reset();
        push(0, {16{8'hA5}}, 2);
        loaded[0] = used[0] + 1;
        wait_idle("drain_single");
        check("single_issued", 128'(issued_cnt), 128'd1);
        check("single_ready_pulses", 128'(used[0]), 128'd1);
        src_data[0 +: 128] = pay(0);

        // All sources valid twice: rotation 0,1,2,3,0,1,2,3.
        do_reset();
        for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) push(k, pay(k), 2);
        for (int k = 0; k < N; k++) loaded[k] = used[k] + 2;
        wait_idle("drain_rr");
        check("rr_issued", 128'(issued_cnt), 128'd8);

        // Block-start flag applies to exactly one grant.
        do_reset();
        @(negedge clk) block_start = 1'b1;
        @(negedge clk) block_start = 1'b0;
        push(2, pay(2) | (128'd1 << 9), 2);
        push(2, pay(2), 2);
        loaded[2] = used[2] + 2;
        wait_idle("drain_blk");

        // Timeout on source 1, then source 3 acked normally.
        do_reset();
        auto_ack = 1'b0;
        push(1, pay(1), TMO);
        push(3, pay(3), 2);
        loaded[1] = used[1] + 1;
        loaded[3] = used[3] + 1;
        for (int c = 0; c < 100 && dropped_cnt == 0; c++) @(negedge clk);
        auto_ack = 1'b1;
        wait_idle("drain_tmo");
        check("tmo_dropped", 128'(dropped_cnt), 128'd1);
        check("tmo_terr", 128'(timeout_err), 128'd1);
        check("tmo_issued", 128'(issued_cnt), 128'd1);

        // accept_i coinciding with ack_i, then reset during an issue.
        do_reset();
        check_reset();
        acc_follow = 1'b1;
        push(0, pay(0), 2);
        loaded[0] = used[0] + 1;
        wait_idle("drain_acc");
        check("acc_issued", 128'(issued_cnt), 128'd1);
        check("acc_accepted", 128'(accepted_cnt), 128'd1);
        acc_follow = 1'b0;
        auto_ack = 1'b0;
        push(2, pay(2), 4);
        loaded[2] = used[2] + 1;
        wait_valid("abort_grant");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset();
        auto_ack = 1'b1;
        push(0, pay(0), 2);
        push(1, pay(1), 2);
        loaded[0] = used[0] + 1;
        loaded[1] = used[1] + 1;
        wait_idle("drain_after_rst");
        check("post_rst_issued", 128'(issued_cnt), 128'd2);

        // Grant enable gating.
        do_reset();
        en = 1'b0;
        loaded[1] = used[1] + 1;
        repeat (5) @(negedge clk);
        check("en_low_valid", 128'(valid), 128'd0);
        check("en_low_busy", 128'(busy), 128'd0);
        check("en_low_ready", 128'(src_ready), 128'd0);
        push(1, pay(1), 2);
        en = 1'b1;
        @(negedge clk);
        check("en_high_valid", 128'(valid), 128'd1);
        check("en_high_busy", 128'(busy), 128'd1);
        wait_idle("drain_en");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/trans_issue_arbiter.md
# trans_issue_arbiter

Round-robin front-end scheduler for the transaction validator. It collects 128-bit transactions from `N_SRC` independent producers and issues exactly one at a time to the validator over its `valid`/`ack` handshake. It also injects the block-start flag (bit 9) on demand and drops stalled issues after a timeout. It keeps wrapping issue, accept and drop counters for the status path.

## Interface
Parameters:
- `N_SRC`, 4: number of requesting producers, 2..8.
- `ACK_TIMEOUT`, 4096: cycles in ISSUE without `ack_i` before the transaction is dropped; must be ≥ 2600 (validator worst-case busy time).
- `GW`, `$clog2(N_SRC)`: grant index width (derived).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `en_i` in 1: grant enable; when low, no new grants (an issue in flight completes).
- `block_start_i` in 1: one-cycle pulse; arms block-start injection.
- `src_data_i` in `N_SRC*128`: producer payloads; slice k is `[k*128 +: 128]`.
- `src_valid_i` in `N_SRC`: producer k has a transaction.
- `src_ready_o` out `N_SRC`: one-cycle pulse; payload k consumed this cycle.
- `data_o` out 128: transaction to validator.
- `valid_o` out 1: transaction valid to validator.
- `ack_i` in 1: validator acknowledge (registered; arrives ≥1 cycle after `valid_o`).
- `accept_i` in 1: validator accepted-transaction pulse (its `valid_o`).
- `grant_o` out GW: index of last/current granted source.
- `busy_o` out 1: high in ISSUE.
- `issued_cnt_o` out 32: acked transactions.
- `accepted_cnt_o` out 32: `accept_i` pulses.
- `dropped_cnt_o` out 32: timed-out transactions.
- `timeout_err_o` out 1: sticky; set on any drop, cleared only by `rst`.

## Operation
- States: IDLE, ISSUE.
- IDLE:
  - If `en_i` and any `src_valid_i`, select the winner g by round-robin: search starts at `(last_grant+1) mod N_SRC` and increments mod N_SRC.
  - Same edge: `data_o <= src_data_i[g]`, with bit 9 OR-ed with `blk_pend`; `src_ready_o[g] <= 1`; `valid_o <= 1`; `grant_o <= g`; clear `blk_pend` if used; clear the timeout counter; go to ISSUE.
  - Otherwise stay in IDLE with `valid_o` = 0.
- ISSUE:
  - `data_o` and `valid_o` are held stable.
  - If `ack_i`: `valid_o <= 0`, `last_grant <= grant_o`, `issued_cnt++`, go to IDLE.
  - Else if timeout counter = `ACK_TIMEOUT-1`: `valid_o <= 0`, `last_grant <= grant_o`, `dropped_cnt++`, `timeout_err <= 1`, go to IDLE; the transaction is lost and is not re-queued.
  - Else: timeout counter++.
- `blk_pend`:
  - Set by `block_start_i`.
  - If the pulse coincides with a grant, the flag applies to that grant and `blk_pend` ends cleared.
  - If a transaction carrying the injected flag times out, `blk_pend` is NOT re-armed.
- `accept_i` increments `accepted_cnt` in any state, including the same cycle as `ack_i`.
- All counters wrap at 2^32 without saturation.
- `en_i` falling while in ISSUE has no effect until return to IDLE.
- A producer deasserting `src_valid_i` before being granted is legal; it is simply skipped.
- Reset values: `valid_o`=0, `src_ready_o`=0, `data_o`=0, `grant_o`=N_SRC-1, `last_grant`=N_SRC-1 (source 0 wins first), all counters 0, `timeout_err_o`=0, `busy_o`=0, `blk_pend`=0, state IDLE.
- `rst` in ISSUE aborts the issue: `valid_o` drops the next edge and no counter is updated.

## Timing
- Grant: the `src_ready_o[g]` pulse and the rising `valid_o` are on the same edge, 1 cycle after `src_valid_i` is sampled high in IDLE.
- Handshake: `valid_o` falls on the edge where `ack_i`=1 is sampled. With an idle validator, `valid_o` is high for exactly 2 cycles.
- Minimum issue period: 3 cycles (ISSUE ×2, IDLE ×1) per transaction.
- Timeout: `valid_o` is high for exactly `ACK_TIMEOUT` cycles before a drop.
- Counter outputs update on the edge of the triggering event (registered, 0 added latency).
- `busy_o` = (state == ISSUE), registered.

## Test plan
- Single source 0, `src_data_i[0]=128'hA5..`, validator acks 1 cycle after valid → `data_o` matches, `valid_o` high 2 cycles, `src_ready_o[0]` one pulse, `issued_cnt_o`=1.
- All 4 sources continuously valid, immediate acks, 8 transactions → grant order 0,1,2,3,0,1,2,3; `issued_cnt_o`=8.
- `block_start_i` pulse, then source 2 payload with bit 9 = 0 → issued `data_o[9]`=1; next transaction `data_o[9]` equals payload bit 9 (0).
- `ACK_TIMEOUT`=16 with `ack_i` held low → `valid_o` high 16 cycles then low, `dropped_cnt_o`=1, `timeout_err_o`=1, next source granted.
- `accept_i` and `ack_i` in the same cycle, then `rst` asserted mid-ISSUE → both counters increment; after reset all outputs at reset values and source 0 is granted first.
- `en_i`=0 with sources valid → no `src_ready_o`; `en_i` raised → grant on the next cycle.
